// File: rtl/operand_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : operand_collector                                                |
// | Brief   : Gathers an instruction's source operands from register_file_bank |
// |           via tagged reads; optional OPERAND_COLLECTOR_ZERO_REG_EN treats  |
// |           register 0 as a hardwired zero.                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module operand_collector #(
    parameter int NumOperands  = 3,
    parameter int NumRegisters = 256,
    parameter int DataWidth    = 32,
    parameter int TagWidth     = 8,
    parameter int InstIdWidth  = 8,
    localparam int AddrW       = $clog2(NumRegisters)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [InstIdWidth-1:0]           in_inst_id_i,
    input  logic [NumOperands-1:0]           in_operand_req_i,
    input  logic [NumOperands*AddrW-1:0]     in_operand_addr_i,
    output logic                             rf_read_valid_o,
    input  logic                             rf_read_ready_i,
    output logic [AddrW-1:0]                 rf_read_addr_o,
    output logic [TagWidth-1:0]              rf_read_tag_o,
    input  logic                             rf_resp_valid_i,
    input  logic [TagWidth-1:0]              rf_resp_tag_i,
    input  logic [DataWidth-1:0]             rf_resp_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [InstIdWidth-1:0]           out_inst_id_o,
    output logic [NumOperands*DataWidth-1:0] out_operands_o,
    output logic                             spurious_resp_o
);

    localparam int IdxW = (NumOperands > 1) ? $clog2(NumOperands) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [InstIdWidth-1:0]           inst_id_q, inst_id_d;
    logic [NumOperands*AddrW-1:0]     addr_q, addr_d;
    logic [NumOperands-1:0]           to_issue_q, to_issue_d;
    logic [NumOperands-1:0]           outstanding_q, outstanding_d;
    logic [NumOperands*DataWidth-1:0] data_q, data_d;
    logic                             spurious_q, spurious_d;
    logic                             in_ready_q, in_ready_d;
    logic                             rd_valid_q, rd_valid_d;
    logic                             out_valid_q, out_valid_d;

    logic [IdxW-1:0]                  sel_idx;
    logic [AddrW-1:0]                 sel_addr;
    logic [NumOperands-1:0]           zero_mask;
    logic                             resp_hit;

    // Lowest pending slot; descending scan so the last match wins.
    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        for (int i = NumOperands - 1; i >= 0; i--) begin
            if (to_issue_q[i]) begin
                sel_idx  = IdxW'(i);
                sel_addr = addr_q[i*AddrW +: AddrW];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        inst_id_d     = inst_id_q;
        addr_d        = addr_q;
        to_issue_d    = to_issue_q;
        outstanding_d = outstanding_q;
        data_d        = data_q;
        spurious_d    = spurious_q;
        resp_hit      = 1'b0;
        zero_mask     = '0;
`ifdef OPERAND_COLLECTOR_ZERO_REG_EN
        for (int i = 0; i < NumOperands; i++) begin
            zero_mask[i] = (in_operand_addr_i[i*AddrW +: AddrW] == '0);
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    inst_id_d     = in_inst_id_i;
                    addr_d        = in_operand_addr_i;
                    to_issue_d    = in_operand_req_i & ~zero_mask;
                    outstanding_d = in_operand_req_i & ~zero_mask;
                    data_d        = '0;
                    state_d       = (to_issue_d == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (rf_resp_valid_i) begin
                    for (int i = 0; i < NumOperands; i++) begin
                        if (rf_resp_tag_i == TagWidth'(i) && outstanding_q[i]) begin
                            data_d[i*DataWidth +: DataWidth] = rf_resp_data_i;
                            outstanding_d[i]                 = 1'b0;
                            resp_hit                         = 1'b1;
                        end
                    end
                    if (!resp_hit) begin
                        spurious_d = 1'b1;
                    end
                end
                if (state_q == ST_ISSUE) begin
                    if (rd_valid_q && rf_read_ready_i) begin
                        for (int i = 0; i < NumOperands; i++) begin
                            if (IdxW'(i) == sel_idx) begin
                                to_issue_d[i] = 1'b0;
                            end
                        end
                    end
                    if (to_issue_d == '0) begin
                        state_d = (outstanding_d == '0) ? ST_DONE : ST_WAIT;
                    end
                end else if (outstanding_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        rd_valid_d  = (state_d == ST_ISSUE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            inst_id_q     <= '0;
            addr_q        <= '0;
            to_issue_q    <= '0;
            outstanding_q <= '0;
            data_q        <= '0;
            spurious_q    <= 1'b0;
            in_ready_q    <= 1'b1;
            rd_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            inst_id_q     <= inst_id_d;
            addr_q        <= addr_d;
            to_issue_q    <= to_issue_d;
            outstanding_q <= outstanding_d;
            data_q        <= data_d;
            spurious_q    <= spurious_d;
            in_ready_q    <= in_ready_d;
            rd_valid_q    <= rd_valid_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign rf_read_valid_o = rd_valid_q;
    assign rf_read_addr_o  = sel_addr;
    assign rf_read_tag_o   = TagWidth'(sel_idx);
    assign out_valid_o     = out_valid_q;
    assign out_inst_id_o   = inst_id_q;
    assign out_operands_o  = data_q;
    assign spurious_resp_o = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_operand_collector                                             |
// | Brief   : Directed self-checking bench for operand_collector.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_operand_collector;

    localparam int NOPS = 3;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int TW   = 8;
    localparam int IW   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [IW-1:0]        in_inst_id_i;
    logic [NOPS-1:0]      in_operand_req_i;
    logic [NOPS*AW-1:0]   in_operand_addr_i;
    logic                 rf_read_valid_o;
    logic                 rf_read_ready_i;
    logic [AW-1:0]        rf_read_addr_o;
    logic [TW-1:0]        rf_read_tag_o;
    logic                 rf_resp_valid_i;
    logic [TW-1:0]        rf_resp_tag_i;
    logic [DW-1:0]        rf_resp_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [IW-1:0]        out_inst_id_o;
    logic [NOPS*DW-1:0]   out_operands_o;
    logic                 spurious_resp_o;

    int n_vec   = 0;
    int n_err   = 0;
    int n_reads = 0;
    logic [DW-1:0] bank_mem [256];

    always #5 clk = ~clk;

    operand_collector #(
        .NumOperands  (NOPS),
        .NumRegisters (256),
        .DataWidth    (DW),
        .TagWidth     (TW),
        .InstIdWidth  (IW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_inst_id_i      (in_inst_id_i),
        .in_operand_req_i  (in_operand_req_i),
        .in_operand_addr_i (in_operand_addr_i),
        .rf_read_valid_o   (rf_read_valid_o),
        .rf_read_ready_i   (rf_read_ready_i),
        .rf_read_addr_o    (rf_read_addr_o),
        .rf_read_tag_o     (rf_read_tag_o),
        .rf_resp_valid_i   (rf_resp_valid_i),
        .rf_resp_tag_i     (rf_resp_tag_i),
        .rf_resp_data_i    (rf_resp_data_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_inst_id_o     (out_inst_id_o),
        .out_operands_o    (out_operands_o),
        .spurious_resp_o   (spurious_resp_o)
    );

    // One clock; with bank_on a 1-cycle bank answers the read accepted this cycle.
    task automatic step(input bit bank_on);
        bit          pend;
        logic [TW-1:0] ptag;
        logic [AW-1:0] paddr;
        pend  = rf_read_valid_o && rf_read_ready_i;
        ptag  = rf_read_tag_o;
        paddr = rf_read_addr_o;
        if (pend) n_reads++;
        @(posedge clk);
        #1;
        if (bank_on) begin
            rf_resp_valid_i = pend;
            rf_resp_tag_i   = pend ? ptag : '0;
            rf_resp_data_i  = pend ? bank_mem[paddr] : '0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid_i = 0; in_inst_id_i = '0; in_operand_req_i = '0; in_operand_addr_i = '0;
        rf_read_ready_i = 0; rf_resp_valid_i = 0; rf_resp_tag_i = '0; rf_resp_data_i = '0;
        out_ready_i = 0;
        step(0);
        step(0);
        n_vec++;
        if ({in_ready_o, rf_read_valid_o, out_valid_o, spurious_resp_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 1000", {in_ready_o, rf_read_valid_o, out_valid_o, spurious_resp_o});
        end
        n_vec++;
        if ({out_inst_id_o, out_operands_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got id=%h ops=%h want 0", out_inst_id_o, out_operands_o);
        end
        rst_n = 1'b1;
        step(0);
    endtask

    task automatic test_basic;
        in_valid_i = 1; in_inst_id_i = 8'd5; in_operand_req_i = 3'b111;
        in_operand_addr_i = {8'd9, 8'd3, 8'd7};
        rf_read_ready_i = 1; out_ready_i = 0;
        step(1);                                   // cycle 1
        in_valid_i = 0;
        n_vec++;
        if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o, in_ready_o} !== {1'b1, 8'd0, 8'd7, 1'b0}) begin
            n_err++;
            $display("FAIL basic_rd0: got v=%b tag=%0d addr=%0d rdy=%b want 1/0/7/0", rf_read_valid_o, rf_read_tag_o, rf_read_addr_o, in_ready_o);
        end
        step(1);                                   // cycle 2
        n_vec++;
        if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o} !== {1'b1, 8'd1, 8'd3}) begin
            n_err++;
            $display("FAIL basic_rd1: got v=%b tag=%0d addr=%0d want 1/1/3", rf_read_valid_o, rf_read_tag_o, rf_read_addr_o);
        end
        step(1);                                   // cycle 3
        n_vec++;
        if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o} !== {1'b1, 8'd2, 8'd9}) begin
            n_err++;
            $display("FAIL basic_rd2: got v=%b tag=%0d addr=%0d want 1/2/9", rf_read_valid_o, rf_read_tag_o, rf_read_addr_o);
        end
        step(1);                                   // cycle 4
        n_vec++;
        if ({rf_read_valid_o, out_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_c4: got rdv=%b outv=%b want 0/0", rf_read_valid_o, out_valid_o);
        end
        step(1);                                   // cycle 5
        n_vec++;
        if ({out_valid_o, out_inst_id_o, out_operands_o} !== {1'b1, 8'd5, 32'h33, 32'h11, 32'h22}) begin
            n_err++;
            $display("FAIL basic_out: got v=%b id=%0d ops=%h want 1/5/00000033_00000011_00000022", out_valid_o, out_inst_id_o, out_operands_o);
        end
        out_ready_i = 1;
        step(1);
        out_ready_i = 0;
        n_vec++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_idle: got rdy=%b outv=%b want 1/0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_stall;
        int reads0;
        reads0 = n_reads;
        in_valid_i = 1; in_inst_id_i = 8'd6; in_operand_req_i = 3'b101;
        in_operand_addr_i = {8'd20, 8'd55, 8'd10};
        rf_read_ready_i = 0;
        step(1);
        in_valid_i = 0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o} !== {1'b1, 8'd0, 8'd10}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got v=%b tag=%0d addr=%0d want 1/0/10", k, rf_read_valid_o, rf_read_tag_o, rf_read_addr_o);
            end
            step(1);
        end
        rf_read_ready_i = 1;
        step(1);
        n_vec++;
        if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o} !== {1'b1, 8'd2, 8'd20}) begin
            n_err++;
            $display("FAIL stall_rd2: got v=%b tag=%0d addr=%0d want 1/2/20", rf_read_valid_o, rf_read_tag_o, rf_read_addr_o);
        end
        step(1);
        step(1);
        n_vec++;
        if ({out_valid_o, out_operands_o, spurious_resp_o} !== {1'b1, 32'hB0B0, 32'h0, 32'hA0A0, 1'b0}) begin
            n_err++;
            $display("FAIL stall_out: got v=%b ops=%h sp=%b want 1/0000b0b0_00000000_0000a0a0/0", out_valid_o, out_operands_o, spurious_resp_o);
        end
        n_vec++;
        if (n_reads - reads0 !== 2) begin
            n_err++;
            $display("FAIL stall_reads: got %0d want 2", n_reads - reads0);
        end
        out_ready_i = 1;
        step(1);
        out_ready_i = 0;
    endtask

    task automatic test_out_of_order;
        in_valid_i = 1; in_inst_id_i = 8'd7; in_operand_req_i = 3'b111;
        in_operand_addr_i = {8'd2, 8'd1, 8'd5};
        rf_read_ready_i = 1; rf_resp_valid_i = 0;
        step(0);
        in_valid_i = 0;
        step(0); step(0); step(0);                 // now in WAIT
        rf_resp_valid_i = 1; rf_resp_tag_i = 8'd2; rf_resp_data_i = 32'hC2;
        step(0);
        rf_resp_tag_i = 8'd0; rf_resp_data_i = 32'hC0;
        step(0);
        rf_resp_tag_i = 8'd1; rf_resp_data_i = 32'hC1;
        n_vec++;
        if (out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL ooo_early: got outv=%b want 0", out_valid_o);
        end
        step(0);
        rf_resp_valid_i = 0;
        n_vec++;
        if ({out_valid_o, out_inst_id_o, out_operands_o} !== {1'b1, 8'd7, 32'hC2, 32'hC1, 32'hC0}) begin
            n_err++;
            $display("FAIL ooo_out: got v=%b id=%0d ops=%h want 1/7/000000c2_000000c1_000000c0", out_valid_o, out_inst_id_o, out_operands_o);
        end
        out_ready_i = 1;
        step(0);
        out_ready_i = 0;
    endtask

    task automatic test_spurious;
        in_valid_i = 1; in_inst_id_i = 8'd8; in_operand_req_i = 3'b011;
        in_operand_addr_i = {8'd0, 8'd7, 8'd3};
        rf_read_ready_i = 1; rf_resp_valid_i = 0;
        step(0);
        in_valid_i = 0;
        step(0); step(0);                          // now in WAIT
        rf_resp_valid_i = 1; rf_resp_tag_i = 8'd3; rf_resp_data_i = 32'hBAD;
        step(0);
        n_vec++;
        if ({spurious_resp_o, out_valid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL spur_flag: got sp=%b outv=%b want 1/0", spurious_resp_o, out_valid_o);
        end
        rf_resp_tag_i = 8'd0; rf_resp_data_i = 32'h11;
        step(0);
        rf_resp_tag_i = 8'd1; rf_resp_data_i = 32'h22;
        step(0);
        rf_resp_valid_i = 0;
        n_vec++;
        if ({out_valid_o, out_operands_o, spurious_resp_o} !== {1'b1, 32'h0, 32'h22, 32'h11, 1'b1}) begin
            n_err++;
            $display("FAIL spur_out: got v=%b ops=%h sp=%b want 1/00000000_00000022_00000011/1", out_valid_o, out_operands_o, spurious_resp_o);
        end
        out_ready_i = 1;
        step(0);
        out_ready_i = 0;
        n_vec++;
        if (spurious_resp_o !== 1'b1) begin
            n_err++;
            $display("FAIL spur_sticky: got %b want 1", spurious_resp_o);
        end
    endtask

    task automatic test_zero_req;
        int reads0;
        reads0 = n_reads;
        in_valid_i = 1; in_inst_id_i = 8'hA5; in_operand_req_i = 3'b000;
        in_operand_addr_i = {8'd1, 8'd2, 8'd3};
        rf_read_ready_i = 1; out_ready_i = 0;
        step(0);
        in_valid_i = 0;
        n_vec++;
        if ({out_valid_o, out_operands_o, rf_read_valid_o} !== {1'b1, 96'h0, 1'b0}) begin
            n_err++;
            $display("FAIL zreq_done: got v=%b ops=%h rdv=%b want 1/0/0", out_valid_o, out_operands_o, rf_read_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({out_valid_o, in_ready_o, out_inst_id_o} !== {1'b1, 1'b0, 8'hA5}) begin
                n_err++;
                $display("FAIL zreq_hold%0d: got v=%b rdy=%b id=%h want 1/0/a5", k, out_valid_o, in_ready_o, out_inst_id_o);
            end
            if (k == 2) out_ready_i = 1;
            step(0);
        end
        out_ready_i = 0;
        n_vec++;
        if ({in_ready_o, out_valid_o} !== 2'b10 || n_reads != reads0) begin
            n_err++;
            $display("FAIL zreq_idle: got rdy=%b outv=%b reads=%0d want 1/0/0", in_ready_o, out_valid_o, n_reads - reads0);
        end
    endtask

    task automatic test_reset_mid;
        in_valid_i = 1; in_inst_id_i = 8'd9; in_operand_req_i = 3'b111;
        in_operand_addr_i = {8'd9, 8'd3, 8'd7};
        rf_read_ready_i = 1; rf_resp_valid_i = 0;
        step(0);                                   // cycle 1
        in_valid_i = 0;
        step(0);                                   // cycle 2
        rf_resp_valid_i = 1; rf_resp_tag_i = 8'd0; rf_resp_data_i = 32'h22;
        step(0);                                   // cycle 3
        rf_resp_valid_i = 0;
        step(0);                                   // cycle 4, WAIT with 2 outstanding
        n_vec++;
        if ({rf_read_valid_o, out_valid_o, in_ready_o} !== 3'b000) begin
            n_err++;
            $display("FAIL rstm_wait: got rdv=%b outv=%b rdy=%b want 000", rf_read_valid_o, out_valid_o, in_ready_o);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready_o, rf_read_valid_o, out_valid_o, spurious_resp_o, out_inst_id_o, out_operands_o} !== {4'b1000, 8'd0, 96'h0}) begin
            n_err++;
            $display("FAIL rstm_async: got rdy=%b rdv=%b outv=%b sp=%b id=%h ops=%h want 1/0/0/0/0/0", in_ready_o, rf_read_valid_o, out_valid_o, spurious_resp_o, out_inst_id_o, out_operands_o);
        end
        step(0);
        rst_n = 1'b1;
        rf_resp_valid_i = 1; rf_resp_tag_i = 8'd1; rf_resp_data_i = 32'h11;
        step(0);
        rf_resp_valid_i = 0;
        n_vec++;
        if ({spurious_resp_o, in_ready_o, out_valid_o, out_operands_o} !== {3'b010, 96'h0}) begin
            n_err++;
            $display("FAIL rstm_late: got sp=%b rdy=%b outv=%b ops=%h want 0/1/0/0", spurious_resp_o, in_ready_o, out_valid_o, out_operands_o);
        end
    endtask

`ifdef OPERAND_COLLECTOR_ZERO_REG_EN
    task automatic test_zero_reg;
        int reads0;
        reads0 = n_reads;
        in_valid_i = 1; in_inst_id_i = 8'd10; in_operand_req_i = 3'b111;
        in_operand_addr_i = {8'd0, 8'd4, 8'd0};
        rf_read_ready_i = 1; rf_resp_valid_i = 0;
        step(1);
        in_valid_i = 0;
        n_vec++;
        if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o} !== {1'b1, 8'd1, 8'd4}) begin
            n_err++;
            $display("FAIL zreg_rd: got v=%b tag=%0d addr=%0d want 1/1/4", rf_read_valid_o, rf_read_tag_o, rf_read_addr_o);
        end
        step(1);
        step(1);
        n_vec++;
        if ({out_valid_o, out_operands_o} !== {1'b1, 32'h0, 32'h44, 32'h0} || n_reads - reads0 != 1) begin
            n_err++;
            $display("FAIL zreg_out: got v=%b ops=%h reads=%0d want 1/00000000_00000044_00000000/1", out_valid_o, out_operands_o, n_reads - reads0);
        end
        out_ready_i = 1;
        step(1);
        out_ready_i = 0;
    endtask
`else
    task automatic test_zero_reg;
        int reads0;
        reads0 = n_reads;
        in_valid_i = 1; in_inst_id_i = 8'd10; in_operand_req_i = 3'b111;
        in_operand_addr_i = {8'd0, 8'd4, 8'd0};
        rf_read_ready_i = 1; rf_resp_valid_i = 0;
        step(1);
        in_valid_i = 0;
        n_vec++;
        if ({rf_read_valid_o, rf_read_tag_o, rf_read_addr_o} !== {1'b1, 8'd0, 8'd0}) begin
            n_err++;
            $display("FAIL r0_rd: got v=%b tag=%0d addr=%0d want 1/0/0", rf_read_valid_o, rf_read_tag_o, rf_read_addr_o);
        end
        step(1); step(1); step(1); step(1);
        n_vec++;
        if ({out_valid_o, out_operands_o} !== {1'b1, 32'hDEAD, 32'h44, 32'hDEAD} || n_reads - reads0 != 3) begin
            n_err++;
            $display("FAIL r0_out: got v=%b ops=%h reads=%0d want 1/0000dead_00000044_0000dead/3", out_valid_o, out_operands_o, n_reads - reads0);
        end
        out_ready_i = 1;
        step(1);
        out_ready_i = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) bank_mem[i] = 32'h1000 + i;
        bank_mem[0]  = 32'hDEAD;
        bank_mem[3]  = 32'h11;
        bank_mem[4]  = 32'h44;
        bank_mem[7]  = 32'h22;
        bank_mem[9]  = 32'h33;
        bank_mem[10] = 32'hA0A0;
        bank_mem[20] = 32'hB0B0;

        test_reset();
        test_basic();
        test_stall();
        test_out_of_order();
        test_zero_req();
        test_spurious();
        test_reset_mid();
        test_zero_reg();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
